// File: rtl/jtbubl_romarb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jtbubl_romarb_pkg                                       |
// | Description : Shared constants, FSM state encoding and helper for     |
// |               the jtbubl ROM slot arbiter.                            |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package jtbubl_romarb_pkg;

    localparam int SLOTS  = 5;
    localparam int DW     = 32;
    localparam int SLOT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Slot index that follows idx, wrapping at the last slot.
    function automatic logic [SLOT_W-1:0] rr_next(input logic [SLOT_W-1:0] idx);
        return (idx == SLOT_W'(SLOTS - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtbubl_romarb_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jtbubl_romarb_slot                                      |
// | Description : Tag, valid bit and data word for one ROM slot. With     |
// |               JTBUBL_ROMARB_CACHE_EN defined the entry survives the   |
// |               slot chip-select going low.                             |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module jtbubl_romarb_slot
    import jtbubl_romarb_pkg::*;
#(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_addr,
    input  logic [DW-1:0] i_load_data,
    output logic          o_ok,
    output logic [DW-1:0] o_dout
);

    logic          r_valid;
    logic [AW-1:0] r_tag;
    logic [DW-1:0] r_data;

    // Tag/data capture; the tag is the address actually fetched, so a slot
    // whose address moved during the access becomes pending again.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            if (i_load) begin
                r_tag  <= i_load_addr;
                r_data <= i_load_data;
            end
`ifdef JTBUBL_ROMARB_CACHE_EN
            if (i_clr)
                r_valid <= 1'b0;
            else if (i_load)
                r_valid <= 1'b1;
`else
            if (i_clr || !i_cs)
                r_valid <= 1'b0;
            else if (i_load)
                r_valid <= 1'b1;
`endif
        end
    end

    // Hit drops in the same cycle the requested address leaves the tag.
    assign o_ok   = i_cs & r_valid & ~i_clr & (i_addr == r_tag);
    assign o_dout = r_data;

endmodule
`default_nettype wire

// File: rtl/jtbubl_romarb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jtbubl_romarb                                           |
// | Description : Five-slot SDRAM ROM arbiter. Graphics slot first during |
// |               active video, round-robin during vertical blank.        |
// |               Optional JTBUBL_ROMARB_CACHE_EN keeps slot contents     |
// |               across chip-select drops.                               |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module jtbubl_romarb
    import jtbubl_romarb_pkg::*;
#(
    parameter int AW       = 22,
    parameter int GFX_SLOT = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [SLOTS-1:0]          slot_cs,
    input  logic [SLOTS-1:0][AW-1:0]  slot_addr,
    output logic [SLOTS-1:0]          slot_ok,
    output logic [SLOTS-1:0][DW-1:0]  slot_dout,
    input  logic                      vblank,
    input  logic                      downloading,
    input  logic                      loop_rst,
    output logic                      sdram_req,
    output logic [AW-1:0]             sdram_addr,
    input  logic                      sdram_ack,
    input  logic                      data_rdy,
    input  logic [DW-1:0]             data_read,
    output logic                      refresh_en
);

    localparam logic [SLOT_W-1:0] c_GFX = SLOT_W'(GFX_SLOT);

    state_t              r_state;
    state_t              w_next;
    logic [SLOT_W-1:0]   r_winner;
    logic [SLOT_W-1:0]   r_ptr;
    logic [AW-1:0]       r_addr;
    logic [SLOTS-1:0]    w_pend;
    logic                w_any;
    logic                w_start;
    logic                w_load;
    logic [SLOT_W-1:0]   w_pick;
    logic [SLOT_W-1:0]   w_fix_pick;
    logic [SLOT_W-1:0]   w_rr_pick;
    logic [SLOT_W-1:0]   w_idx;
    logic                w_rr_hit;

    assign w_pend = slot_cs & ~slot_ok;
    assign w_any  = |w_pend;

    // Winner selection: fixed priority in active video, rotating in vblank.
    always_comb begin
        w_fix_pick = '0;
        w_rr_pick  = '0;
        w_rr_hit   = 1'b0;
        w_idx      = r_ptr;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (w_pend[i])
                w_fix_pick = SLOT_W'(i);
        end
        if (w_pend[GFX_SLOT])
            w_fix_pick = c_GFX;
        for (int i = 0; i < SLOTS; i++) begin
            if (!w_rr_hit && w_pend[w_idx]) begin
                w_rr_pick = w_idx;
                w_rr_hit  = 1'b1;
            end
            w_idx = rr_next(w_idx);
        end
        w_pick = vblank ? w_rr_pick : w_fix_pick;
    end

    // Next-state and strobe logic; loop_rst overrides everything.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!downloading && w_any) begin
                    w_next  = ST_REQ;
                    w_start = 1'b1;
                end
            end
            ST_REQ: begin
                if (sdram_ack)
                    w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_rdy) begin
                    w_next = ST_DONE;
                    w_load = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (loop_rst) begin
            w_next  = ST_IDLE;
            w_start = 1'b0;
            w_load  = 1'b0;
        end
    end

    // State register plus winner, request address and rotation pointer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_winner <= '0;
            r_ptr    <= '0;
            r_addr   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_winner <= w_pick;
                r_addr   <= slot_addr[w_pick];
                r_ptr    <= rr_next(w_pick);
            end
        end
    end

    assign sdram_req  = (r_state == ST_REQ);
    assign sdram_addr = r_addr;
    assign refresh_en = downloading | ((r_state == ST_IDLE) & ~w_any);

    generate
        for (genvar i = 0; i < SLOTS; i++) begin : g_slot
            jtbubl_romarb_slot #(
                .AW (AW)
            ) u_slot (
                .clk         (clk),
                .rstn        (rstn),
                .i_cs        (slot_cs[i]),
                .i_addr      (slot_addr[i]),
                .i_clr       (downloading),
                .i_load      (w_load && (r_winner == SLOT_W'(i))),
                .i_load_addr (r_addr),
                .i_load_data (data_read),
                .o_ok        (slot_ok[i]),
                .o_dout      (slot_dout[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_jtbubl_romarb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_jtbubl_romarb                                        |
// | Description : Directed bench for jtbubl_romarb with an SDRAM          |
// |               responder and an expected-access queue.                 |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_jtbubl_romarb;

    localparam int AW = 22;
    localparam int NS = 5;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NS-1:0]         slot_cs;
    logic [NS-1:0][AW-1:0] slot_addr;
    logic [NS-1:0]         slot_ok;
    logic [NS-1:0][31:0]   slot_dout;
    logic                  vblank, downloading, loop_rst;
    logic                  sdram_req;
    logic [AW-1:0]         sdram_addr;
    logic                  sdram_ack, data_rdy;
    logic [31:0]           data_read;
    logic                  refresh_en;

    typedef struct packed {
        int            slot;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   req_cnt = 0;
    int   r0;
    exp_t e_keep;
    bit   got;

    jtbubl_romarb dut (
        .clk         (clk),
        .rstn        (rstn),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .vblank      (vblank),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sdram_req) req_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output bit found);
        int n;
        found = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (sdram_req) begin
                found = 1'b1;
                break;
            end
            n++;
        end
    endtask

    // Serve one access: check address, ack, then return data (or abort).
    task automatic serve(input int ack_wait, input int rdy_wait, input bit abort);
        exp_t e;
        bit   f;
        wait_req(f);
        chk("req_seen", {159'd0, f}, 160'd1);
        if (!f) return;
        chk("queue_nonempty", {159'd0, (q.size() > 0)}, 160'd1);
        if (q.size() == 0) return;
        e = q.pop_front();
        chk("sdram_addr", {138'd0, sdram_addr}, {138'd0, e.addr});
        repeat (ack_wait) @(posedge clk);
        #1 sdram_ack = 1'b1;
        @(posedge clk);
        #1 sdram_ack = 1'b0;
        @(negedge clk);
        chk("req_drop", {159'd0, sdram_req}, 160'd0);
        chk("ok_before_data", {159'd0, slot_ok[e.slot]}, 160'd0);
        if (abort) begin
            loop_rst = 1'b1;
            @(posedge clk);
            #1 loop_rst = 1'b0;
            data_rdy  = 1'b1;
            data_read = e.data;
            @(negedge clk);
            chk("abort_req_low", {159'd0, sdram_req}, 160'd0);
            @(posedge clk);
            #1 data_rdy = 1'b0;
            data_read = 32'h5A5A_5A5A;
            @(negedge clk);
            chk("abort_no_ok", {159'd0, slot_ok[e.slot]}, 160'd0);
            return;
        end
        repeat (rdy_wait) @(posedge clk);
        #1 data_rdy = 1'b1;
        data_read = e.data;
        @(posedge clk);
        #1 data_rdy = 1'b0;
        data_read = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("ok_after_data", {159'd0, slot_ok[e.slot]}, 160'd1);
        chk("dout", {128'd0, slot_dout[e.slot]}, {128'd0, e.data});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; slot_cs = '0; slot_addr = '0; vblank = 1'b0;
        downloading = 1'b0; loop_rst = 1'b0; sdram_ack = 1'b0;
        data_rdy = 1'b0; data_read = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {159'd0, sdram_req}, 160'd0);
        chk("rst_addr", {138'd0, sdram_addr}, 160'd0);
        chk("rst_refresh", {159'd0, refresh_en}, 160'd1);
        chk("rst_ok", {155'd0, slot_ok}, 160'd0);
        chk("rst_dout", slot_dout, 160'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single request on slot 0.
        slot_addr[0] = 22'h00100;
        q.push_back('{0, 22'h00100, 32'hDEADBEEF});
        @(posedge clk);
        #1 slot_cs[0] = 1'b1;
        r0 = req_cnt;
        @(negedge clk);
        chk("pend_refresh", {159'd0, refresh_en}, 160'd0);
        serve(1, 1, 0);
        chk("req_len", 160'(req_cnt - r0), 160'd2);

        // Active-video priority: slot 4 before slot 1.
        @(posedge clk);
        #1 slot_addr[1] = 22'h01234; slot_addr[4] = 22'h2ABCD;
        slot_cs[1] = 1'b1; slot_cs[4] = 1'b1;
        q.push_back('{4, 22'h2ABCD, 32'h4444_0004});
        q.push_back('{1, 22'h01234, 32'h1111_0001});
        serve(2, 3, 0);
        serve(1, 1, 0);
        chk("slot0_still_ok", {159'd0, slot_ok[0]}, 160'd1);
        @(posedge clk);
        #1 slot_cs = '0;

        // Vblank round-robin from a reset pointer: 0, 2, 3, 0.
        do_reset();
        @(posedge clk);
        #1 vblank = 1'b1;
        slot_addr[0] = 22'h00010; slot_addr[2] = 22'h00200; slot_addr[3] = 22'h03000;
        slot_cs = 5'b01101;
        q.push_back('{0, 22'h00010, 32'h0000_00A0});
        q.push_back('{2, 22'h00200, 32'h0000_00A2});
        q.push_back('{3, 22'h03000, 32'h0000_00A3});
        serve(1, 1, 0);
        slot_addr[0] = 22'h00020;
        q.push_back('{0, 22'h00020, 32'h0000_00B0});
        serve(1, 1, 0);
        serve(1, 2, 0);
        serve(1, 1, 0);
        @(posedge clk);
        #1 slot_cs = '0; vblank = 1'b0;

        // Abort in WAIT, late data ignored, then reissue.
        @(posedge clk);
        #1 slot_addr[1] = 22'h15555; slot_cs[1] = 1'b1;
        e_keep = '{1, 22'h15555, 32'hCAFE_0001};
        q.push_back(e_keep);
        serve(1, 1, 1);
        q.push_back(e_keep);
        serve(1, 1, 0);
        @(posedge clk);
        #1 slot_cs = '0;

        // Slot 2 cache behaviour across a chip-select drop.
        @(posedge clk);
        #1 slot_addr[2] = 22'h3C000; slot_cs[2] = 1'b1;
        q.push_back('{2, 22'h3C000, 32'h3C3C_0002});
        serve(1, 1, 0);
        @(posedge clk);
        #1 slot_cs[2] = 1'b0;
        repeat (10) @(posedge clk);
`ifdef JTBUBL_ROMARB_CACHE_EN
        #1 slot_cs[2] = 1'b1;
        r0 = req_cnt;
        @(negedge clk);
        chk("cache_hit_ok", {159'd0, slot_ok[2]}, 160'd1);
        chk("cache_hit_dout", {128'd0, slot_dout[2]}, {128'd0, 32'h3C3C_0002});
        repeat (5) @(negedge clk);
        chk("cache_no_req", 160'(req_cnt - r0), 160'd0);
`else
        #1 slot_cs[2] = 1'b1;
        q.push_back('{2, 22'h3C000, 32'h3C3C_0022});
        @(negedge clk);
        chk("nocache_miss", {159'd0, slot_ok[2]}, 160'd0);
        serve(1, 1, 0);
`endif
        @(posedge clk);
        #1 slot_cs = '0;

        // Reset while in REQ.
        @(posedge clk);
        #1 slot_addr[3] = 22'h0ABCD; slot_cs[3] = 1'b1;
        wait_req(got);
        chk("req3_seen", {159'd0, got}, 160'd1);
        rstn = 1'b0; slot_cs = '0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rreq_req", {159'd0, sdram_req}, 160'd0);
        chk("rreq_addr", {138'd0, sdram_addr}, 160'd0);
        chk("rreq_refresh", {159'd0, refresh_en}, 160'd1);
        chk("rreq_dout", slot_dout, 160'd0);

        // Download blocks access and invalidates tags.
        @(posedge clk);
        #1 slot_addr[0] = 22'h00777; slot_cs[0] = 1'b1;
        q.push_back('{0, 22'h00777, 32'h7777_0000});
        serve(1, 1, 0);
        @(posedge clk);
        #1 downloading = 1'b1;
        slot_addr[1] = 22'h01111; slot_cs[1] = 1'b1;
        @(negedge clk);
        chk("dl_ok", {155'd0, slot_ok}, 160'd0);
        chk("dl_refresh", {159'd0, refresh_en}, 160'd1);
        r0 = req_cnt;
        repeat (4) @(negedge clk);
        chk("dl_no_req", 160'(req_cnt - r0), 160'd0);
        q.push_back('{0, 22'h00777, 32'h7777_1000});
        q.push_back('{1, 22'h01111, 32'h1111_1000});
        @(posedge clk);
        #1 downloading = 1'b0;
        @(negedge clk);
        chk("dl_tag_invalid", {159'd0, slot_ok[0]}, 160'd0);
        serve(1, 1, 0);
        serve(1, 1, 0);
        @(posedge clk);
        #1 slot_cs = '0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
